// File: rtl/aha_reset_req_sequencer.sv
// Combines masked reset request sources into one registered, stretched system reset
// request pulse. It also keeps a sticky cause record and a saturating event counter.
`timescale 1ns/1ps
module aha_reset_req_sequencer #(
    parameter int NUM_SRC        = 4,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] REQ,
    input  logic [NUM_SRC-1:0] REQ_EN,
    input  logic               CAUSE_CLR,
    output logic               SYSRESETREQ_OUT,
    output logic [NUM_SRC-1:0] CAUSE,
    output logic               BUSY,
    output logic [7:0]         EVENT_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_e;

    localparam logic [7:0] PULSE_LD   = 8'(PULSE_CYCLES - 1);
    localparam bit         NO_HOLDOFF = (HOLDOFF_CYCLES == 0);
    localparam logic [7:0] HOLD_LD    = NO_HOLDOFF ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] en_mask;
    logic [NUM_SRC-1:0] req_q, req_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         evt_q, evt_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;

    always_comb begin
        // Source 0 (CPU SYSRESETREQ) cannot be masked.
        en_mask    = REQ_EN;
        en_mask[0] = 1'b1;
        req_d      = REQ & en_mask;

        // Set wins over clear on a colliding cycle.
        cause_d = (CAUSE_CLR ? '0 : cause_q) | req_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        case (state_q)
            S_IDLE: begin
                if (|req_q) begin
                    state_d = S_ASSERT;
                    cnt_d   = PULSE_LD;
                    if (evt_q != 8'hFF) evt_d = evt_q + 8'd1;
                end
            end
            S_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    if (NO_HOLDOFF) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        out_d  = (state_d == S_ASSERT);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cause_q <= '0;
            cnt_q   <= 8'd0;
            evt_q   <= 8'd0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign SYSRESETREQ_OUT = out_q;
    assign CAUSE           = cause_q;
    assign BUSY            = busy_q;
    assign EVENT_COUNT     = evt_q;

endmodule

// File: tb/tb_aha_reset_req_sequencer.sv
// Directed bench for aha_reset_req_sequencer: default instance plus a 1-cycle-pulse,
// zero-holdoff instance used for the saturation run.
`timescale 1ns/1ps
module tb_aha_reset_req_sequencer;

    logic       clk = 1'b0;
    logic       rst, rst2;
    logic [3:0] req, req_en, req2, req_en2;
    logic       clr, clr2;
    logic       out, busy, out2, busy2;
    logic [3:0] cause, cause2;
    logic [7:0] evt, evt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aha_reset_req_sequencer #(.NUM_SRC(4), .PULSE_CYCLES(16), .HOLDOFF_CYCLES(8)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .REQ_EN(req_en), .CAUSE_CLR(clr),
        .SYSRESETREQ_OUT(out), .CAUSE(cause), .BUSY(busy), .EVENT_COUNT(evt)
    );

    aha_reset_req_sequencer #(.NUM_SRC(4), .PULSE_CYCLES(1), .HOLDOFF_CYCLES(0)) dut_sat (
        .CLK(clk), .RESET(rst2), .REQ(req2), .REQ_EN(req_en2), .CAUSE_CLR(clr2),
        .SYSRESETREQ_OUT(out2), .CAUSE(cause2), .BUSY(busy2), .EVENT_COUNT(evt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic measure_pulse(output int hi, output int lo);
        hi = 0;
        while (out === 1'b1 && hi < 300) begin
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (out === 1'b0 && busy === 1'b1 && lo < 300) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi, lo, mism;
        logic seen, exp_o;

        rst = 1'b1; rst2 = 1'b1;
        req = '0; req_en = '0; clr = 1'b0;
        req2 = '0; req_en2 = '0; clr2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out",   32'(out),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_evt",   32'(evt),   32'd0);
        check("rst_evt2",  32'(evt2),  32'd0);
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Single one-cycle request on source 0
        req = 4'b0001;
        @(negedge clk);
        check("t1_lat0", 32'(out), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("t1_lat1", 32'(out), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        measure_pulse(hi, lo);
        check("t1_hi", 32'(hi), 32'd16);
        check("t1_lo", 32'(lo), 32'd8);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_evt", 32'(evt), 32'd1);
        check("t1_cause", 32'(cause), 32'd1);

        // Masked source produces nothing, then enabled produces one pulse
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t2_clr", 32'(cause), 32'd0);
        req = 4'b0100; req_en = 4'b0000;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out === 1'b1) seen = 1'b1;
        end
        check("t2_masked_out", 32'(seen), 32'd0);
        check("t2_masked_cause", 32'(cause), 32'd0);
        check("t2_masked_busy", 32'(busy), 32'd0);
        req_en = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("t2_out", 32'(out), 32'd1);
        measure_pulse(hi, lo);
        check("t2_hi", 32'(hi), 32'd16);
        check("t2_lo", 32'(lo), 32'd8);
        check("t2_cause", 32'(cause), 32'd4);
        check("t2_evt", 32'(evt), 32'd2);

        // Clear colliding with a new request bit; late request ignored mid-pulse
        clr = 1'b1; req = 4'b0001; req_en = 4'b0000;
        @(negedge clk);
        clr = 1'b0; req = 4'b1000; req_en = 4'b1000;
        @(negedge clk);
        check("t3_prior_cause", 32'(cause), 32'd1);
        req = 4'b0000; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_collide_cause", 32'(cause), 32'd8);
        check("t3_out", 32'(out), 32'd1);
        wait_idle("t3_idle");
        repeat (3) @(negedge clk);
        check("t3_evt", 32'(evt), 32'd3);
        check("t3_no_retrig", 32'(out), 32'd0);
        check("t3_cause_hold", 32'(cause), 32'd8);

        // Held source 0 for 60 cycles, source 1 pulsed during holdoff
        clr = 1'b1; req_en = 4'b0010;
        @(negedge clk);
        clr = 1'b0;
        req = 4'b0001;
        mism = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            exp_o = (i >= 2) && (((i - 2) % 25) < 16);
            if (out !== exp_o) mism++;
            if (i == 20) req = 4'b0011;
            if (i == 21) req = 4'b0001;
        end
        req = 4'b0000;
        check("t4_train_mism", 32'(mism), 32'd0);
        wait_idle("t4_idle");
        check("t4_cause", 32'(cause), 32'd3);
        check("t4_evt", 32'(evt), 32'd6);

        // Asynchronous reset at pulse cycle 5
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("t5_pre_out", 32'(out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_out", 32'(out), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cause", 32'(cause), 32'd0);
        check("t5_evt", 32'(evt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_held_out", 32'(out), 32'd0);
        req = 4'b0001;
        @(negedge clk);
        check("t5_post_lat0", 32'(out), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("t5_post_lat1", 32'(out), 32'd1);
        check("t5_post_evt", 32'(evt), 32'd1);
        wait_idle("t5_idle");

        // Saturation with 1-cycle pulses and no holdoff
        req2 = 4'b0001;
        mism = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            exp_o = (i >= 2) && ((i % 2) == 0);
            if (out2 !== exp_o) mism++;
            if (i == 509) check("t6_evt_254", 32'(evt2), 32'd254);
            if (i == 510) check("t6_evt_255", 32'(evt2), 32'd255);
        end
        req2 = 4'b0000;
        check("t6_train_mism", 32'(mism), 32'd0);
        check("t6_evt_sat", 32'(evt2), 32'd255);
        check("t6_cause", 32'(cause2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
